// File: rtl/cmd_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the command-bus arbiter.
package cmd_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } arb_state_e;

  // Read data returned to a requester whose transaction timed out.
  localparam logic [31:0] CMD_ERR_RDATA = 32'hDEADBEEF;

  // The picker works on a fixed-width request vector; callers zero-extend.
  localparam int RR_MAX_REQ = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req scanning upward from (last + 1) mod num, with wrap.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                       input logic [2:0]            last,
                                       input logic [3:0]            num);
    rr_pick_t   res;
    logic [3:0] idx;
    res = '0;
    for (int i = 1; i <= RR_MAX_REQ; i++) begin
      idx = {1'b0, last} + 4'(i);
      if (idx >= num) idx = idx - num;
      if (!res.valid && (4'(i) <= num) && req[idx[2:0]]) begin
        res.valid = 1'b1;
        res.idx   = idx[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cmd_bus_arbiter_rr.sv
// Combinational rotating-priority picker: lowest index after the last grantee wins.
module rr_arbiter
  import cmd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_last,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_valid
);

  logic [RR_MAX_REQ-1:0] w_req_pad;
  rr_pick_t              w_pick;

  // Zero-extend the request vector onto the picker's fixed width and pick.
  always_comb begin
    w_req_pad              = '0;
    w_req_pad[NUM_REQ-1:0] = i_req;
    w_pick                 = rr_pick(w_req_pad, 3'(i_last), 4'(NUM_REQ));
  end

  assign o_idx   = ($clog2(NUM_REQ))'(w_pick.idx);
  assign o_valid = w_pick.valid;

endmodule

// File: rtl/cmd_bus_arbiter.sv
// Round-robin arbiter sharing one command-bus master between NUM_REQ requesters,
// with a single-cycle sel pulse per transaction and a no-ack timeout.
module cmd_bus_arbiter
  import cmd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_BITS      = 16,
  parameter int unsigned CMD_DATA_BITS  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             i_sysclk,
  input  logic                             i_srst,
  input  logic [NUM_REQ-1:0]               i_req_sel,
  input  logic [NUM_REQ-1:0]               i_req_rd_wr_n,
  input  logic [NUM_REQ*ADDR_BITS-1:0]     i_req_byte_addr,
  input  logic [NUM_REQ*CMD_DATA_BITS-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]               o_req_ack,
  output logic [NUM_REQ-1:0]               o_req_err,
  output logic [CMD_DATA_BITS-1:0]         o_req_rdata,
  output logic                             o_cmd_sel,
  output logic                             o_cmd_rd_wr_n,
  output logic [ADDR_BITS-1:0]             o_cmd_byte_addr,
  output logic [CMD_DATA_BITS-1:0]         o_cmd_wdata,
  input  logic [CMD_DATA_BITS-1:0]         i_cmd_rdata,
  input  logic                             i_cmd_ack
);

  localparam int unsigned IDX_BITS = $clog2(NUM_REQ);
  localparam int unsigned TMR_BITS = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(TIMEOUT_CYCLES - 1);

  arb_state_e                 r_state, w_state_next;
  logic [IDX_BITS-1:0]        r_grant, w_grant_next;
  logic [IDX_BITS-1:0]        r_last_grant, w_last_grant_next;
  logic [TMR_BITS-1:0]        r_timer, w_timer_next;
  logic                       r_cmd_sel, w_cmd_sel_next;
  logic                       r_cmd_rd_wr_n, w_cmd_rd_wr_n_next;
  logic [ADDR_BITS-1:0]       r_cmd_byte_addr, w_cmd_byte_addr_next;
  logic [CMD_DATA_BITS-1:0]   r_cmd_wdata, w_cmd_wdata_next;
  logic [NUM_REQ-1:0]         r_req_ack, w_req_ack_next;
  logic [NUM_REQ-1:0]         r_req_err, w_req_err_next;
  logic [CMD_DATA_BITS-1:0]   r_req_rdata, w_req_rdata_next;

  logic [IDX_BITS-1:0]        w_pick_idx;
  logic                       w_pick_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req   (i_req_sel),
    .i_last  (r_last_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Next-state and next-output logic; sel/ack/err default low so they pulse for one cycle.
  always_comb begin
    w_state_next         = r_state;
    w_grant_next         = r_grant;
    w_last_grant_next    = r_last_grant;
    w_timer_next         = r_timer;
    w_cmd_sel_next       = 1'b0;
    w_cmd_rd_wr_n_next   = r_cmd_rd_wr_n;
    w_cmd_byte_addr_next = r_cmd_byte_addr;
    w_cmd_wdata_next     = r_cmd_wdata;
    w_req_ack_next       = '0;
    w_req_err_next       = '0;
    w_req_rdata_next     = r_req_rdata;
    unique case (r_state)
      StIdle: begin
        if (w_pick_valid) begin
          w_grant_next         = w_pick_idx;
          w_cmd_rd_wr_n_next   = i_req_rd_wr_n[w_pick_idx];
          w_cmd_byte_addr_next = i_req_byte_addr[int'(w_pick_idx)*ADDR_BITS +: ADDR_BITS];
          w_cmd_wdata_next     = i_req_wdata[int'(w_pick_idx)*CMD_DATA_BITS +: CMD_DATA_BITS];
          // Registered, so sel is visible exactly during the ISSUE cycle.
          w_cmd_sel_next       = 1'b1;
          w_state_next         = StIssue;
        end
      end
      StIssue: begin
        w_timer_next = '0;
        w_state_next = StWait;
      end
      StWait: begin
        // A real ack in the last WAIT cycle takes precedence over the timeout.
        if (i_cmd_ack) begin
          if (r_cmd_rd_wr_n) w_req_rdata_next = i_cmd_rdata;
          w_req_ack_next[r_grant] = 1'b1;
          w_state_next            = StDone;
        end else if (r_timer == TMR_LAST) begin
          w_req_ack_next[r_grant] = 1'b1;
          w_req_err_next[r_grant] = 1'b1;
          w_req_rdata_next        = CMD_DATA_BITS'(CMD_ERR_RDATA);
          w_state_next            = StDone;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      StDone: begin
        w_last_grant_next = r_grant;
        w_state_next      = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State and output registers with synchronous reset; requester 0 gets first priority.
  always_ff @(posedge i_sysclk) begin
    if (i_srst) begin
      r_state         <= StIdle;
      r_grant         <= '0;
      r_last_grant    <= IDX_BITS'(NUM_REQ - 1);
      r_timer         <= '0;
      r_cmd_sel       <= 1'b0;
      r_cmd_rd_wr_n   <= 1'b0;
      r_cmd_byte_addr <= '0;
      r_cmd_wdata     <= '0;
      r_req_ack       <= '0;
      r_req_err       <= '0;
      r_req_rdata     <= '0;
    end else begin
      r_state         <= w_state_next;
      r_grant         <= w_grant_next;
      r_last_grant    <= w_last_grant_next;
      r_timer         <= w_timer_next;
      r_cmd_sel       <= w_cmd_sel_next;
      r_cmd_rd_wr_n   <= w_cmd_rd_wr_n_next;
      r_cmd_byte_addr <= w_cmd_byte_addr_next;
      r_cmd_wdata     <= w_cmd_wdata_next;
      r_req_ack       <= w_req_ack_next;
      r_req_err       <= w_req_err_next;
      r_req_rdata     <= w_req_rdata_next;
    end
  end

  assign o_req_ack       = r_req_ack;
  assign o_req_err       = r_req_err;
  assign o_req_rdata     = r_req_rdata;
  assign o_cmd_sel       = r_cmd_sel;
  assign o_cmd_rd_wr_n   = r_cmd_rd_wr_n;
  assign o_cmd_byte_addr = r_cmd_byte_addr;
  assign o_cmd_wdata     = r_cmd_wdata;

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// Directed self-checking bench for cmd_bus_arbiter with a simple delayed-ack slave model.
module tb_cmd_bus_arbiter;

  localparam int NR = 4;
  localparam int AB = 16;
  localparam int DB = 32;
  localparam int TO = 16;

  logic              i_sysclk = 1'b0;
  logic              i_srst;
  logic [NR-1:0]     i_req_sel;
  logic [NR-1:0]     i_req_rd_wr_n;
  logic [NR*AB-1:0]  i_req_byte_addr;
  logic [NR*DB-1:0]  i_req_wdata;
  logic [NR-1:0]     o_req_ack;
  logic [NR-1:0]     o_req_err;
  logic [DB-1:0]     o_req_rdata;
  logic              o_cmd_sel;
  logic              o_cmd_rd_wr_n;
  logic [AB-1:0]     o_cmd_byte_addr;
  logic [DB-1:0]     o_cmd_wdata;
  logic [DB-1:0]     i_cmd_rdata;
  logic              i_cmd_ack;

  // Slave model controls: ack sl_delay cycles after the sel cycle (1 = next cycle).
  logic              sl_en = 1'b0;
  int                sl_delay = 1;
  logic [DB-1:0]     sl_data = '0;
  int                sl_cnt = 0;
  logic              sl_ack = 1'b0;
  logic [DB-1:0]     sl_rdata = '0;
  logic              spur_ack = 1'b0;
  logic [DB-1:0]     sel_wdata_q[$];

  int n_cmp;
  int n_bad;

  assign i_cmd_ack   = sl_ack | spur_ack;
  assign i_cmd_rdata = spur_ack ? 32'hBAD0BAD0 : sl_rdata;

  cmd_bus_arbiter #(
    .NUM_REQ        (NR),
    .ADDR_BITS      (AB),
    .CMD_DATA_BITS  (DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_sysclk        (i_sysclk),
    .i_srst          (i_srst),
    .i_req_sel       (i_req_sel),
    .i_req_rd_wr_n   (i_req_rd_wr_n),
    .i_req_byte_addr (i_req_byte_addr),
    .i_req_wdata     (i_req_wdata),
    .o_req_ack       (o_req_ack),
    .o_req_err       (o_req_err),
    .o_req_rdata     (o_req_rdata),
    .o_cmd_sel       (o_cmd_sel),
    .o_cmd_rd_wr_n   (o_cmd_rd_wr_n),
    .o_cmd_byte_addr (o_cmd_byte_addr),
    .o_cmd_wdata     (o_cmd_wdata),
    .i_cmd_rdata     (i_cmd_rdata),
    .i_cmd_ack       (i_cmd_ack)
  );

  always #5 i_sysclk = ~i_sysclk;

  // Slave: samples sel, then pulses ack with read data after the programmed delay.
  always @(posedge i_sysclk) begin
    sl_ack <= 1'b0;
    if (!sl_en) begin
      sl_cnt <= 0;
    end else if (o_cmd_sel) begin
      sel_wdata_q.push_back(o_cmd_wdata);
      if (sl_delay <= 1) begin
        sl_ack   <= 1'b1;
        sl_rdata <= sl_data;
        sl_cnt   <= 0;
      end else begin
        sl_cnt <= sl_delay - 1;
      end
    end else if (sl_cnt == 1) begin
      sl_ack   <= 1'b1;
      sl_rdata <= sl_data;
      sl_cnt   <= 0;
    end else if (sl_cnt > 1) begin
      sl_cnt <= sl_cnt - 1;
    end
  end

  task automatic tick();
    @(posedge i_sysclk);
    #1;
  endtask

  // Leaves the DUT in its reset state; the caller's next drive is cycle 0 in IDLE.
  task automatic do_reset();
    i_req_sel       = '0;
    i_req_rd_wr_n   = '0;
    i_req_byte_addr = '0;
    i_req_wdata     = '0;
    spur_ack        = 1'b0;
    sl_en           = 1'b0;
    i_srst          = 1'b1;
    tick();
    tick();
    i_srst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (o_cmd_sel !== 1'b0) begin n_bad++; $display("FAIL rst_sel got %b exp 0", o_cmd_sel); end
    n_cmp++; if (o_req_ack !== 4'b0) begin n_bad++; $display("FAIL rst_ack got %b exp 0000", o_req_ack); end
    n_cmp++; if (o_req_err !== 4'b0) begin n_bad++; $display("FAIL rst_err got %b exp 0000", o_req_err); end
    n_cmp++; if (o_req_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h exp 0", o_req_rdata); end
    n_cmp++; if (o_cmd_byte_addr !== 16'h0) begin n_bad++; $display("FAIL rst_addr got %h exp 0", o_cmd_byte_addr); end
    n_cmp++; if (o_cmd_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata got %h exp 0", o_cmd_wdata); end
    n_cmp++; if (o_cmd_rd_wr_n !== 1'b0) begin n_bad++; $display("FAIL rst_rdwr got %b exp 0", o_cmd_rd_wr_n); end
  endtask

  task automatic test_single_read();
    logic [NR-1:0] exp_ack;
    do_reset();
    sl_en = 1'b1; sl_delay = 1; sl_data = 32'h12345678;
    i_req_rd_wr_n[0] = 1'b1;
    i_req_byte_addr[0 +: AB] = 16'h0004;
    i_req_sel[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_ack = (k == 3) ? 4'b0001 : 4'b0000;
      n_cmp++; if (o_cmd_sel !== (k == 1)) begin n_bad++; $display("FAIL rd_sel c%0d got %b exp %b", k, o_cmd_sel, (k == 1)); end
      n_cmp++; if (o_req_ack !== exp_ack) begin n_bad++; $display("FAIL rd_ack c%0d got %b exp %b", k, o_req_ack, exp_ack); end
      n_cmp++; if (o_req_err !== 4'b0) begin n_bad++; $display("FAIL rd_err c%0d got %b exp 0000", k, o_req_err); end
      if (k == 1) begin
        n_cmp++; if (o_cmd_byte_addr !== 16'h0004) begin n_bad++; $display("FAIL rd_addr got %h exp 0004", o_cmd_byte_addr); end
        n_cmp++; if (o_cmd_rd_wr_n !== 1'b1) begin n_bad++; $display("FAIL rd_rdwr got %b exp 1", o_cmd_rd_wr_n); end
      end
      if (k == 3) begin
        n_cmp++; if (o_req_rdata !== 32'h12345678) begin n_bad++; $display("FAIL rd_rdata got %h exp 12345678", o_req_rdata); end
        i_req_sel[0] = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_all_four();
    logic [NR-1:0] exp_ack;
    logic          exp_sel;
    logic [DB-1:0] got;
    do_reset();
    sel_wdata_q.delete();
    sl_en = 1'b1; sl_delay = 1; sl_data = 32'h0;
    for (int r = 0; r < NR; r++) begin
      i_req_byte_addr[r*AB +: AB] = 16'h0004;
      i_req_wdata[r*DB +: DB]     = 32'hA0 + 32'(r);
    end
    i_req_sel = 4'b1111;
    for (int k = 0; k < 18; k++) begin
      exp_sel = (k < 16) && (k % 4 == 1);
      exp_ack = ((k < 16) && (k % 4 == 3)) ? 4'(1 << (k / 4)) : 4'b0000;
      n_cmp++; if (o_cmd_sel !== exp_sel) begin n_bad++; $display("FAIL all4_sel c%0d got %b exp %b", k, o_cmd_sel, exp_sel); end
      n_cmp++; if (o_req_ack !== exp_ack) begin n_bad++; $display("FAIL all4_ack c%0d got %b exp %b", k, o_req_ack, exp_ack); end
      if (exp_sel) begin
        n_cmp++; if (o_cmd_rd_wr_n !== 1'b0) begin n_bad++; $display("FAIL all4_rdwr c%0d got %b exp 0", k, o_cmd_rd_wr_n); end
      end
      i_req_sel = i_req_sel & ~o_req_ack;
      tick();
    end
    n_cmp++; if (sel_wdata_q.size() != 4) begin n_bad++; $display("FAIL all4_nsel got %0d exp 4", sel_wdata_q.size()); end
    for (int i = 0; i < 4 && i < sel_wdata_q.size(); i++) begin
      got = sel_wdata_q[i];
      n_cmp++; if (got !== 32'hA0 + 32'(i)) begin n_bad++; $display("FAIL all4_wdata #%0d got %h exp %h", i, got, 32'hA0 + 32'(i)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] exp_ack;
    logic [NR-1:0] reraise;
    int            n_ack;
    do_reset();
    sl_en = 1'b1; sl_delay = 1; sl_data = 32'h0;
    i_req_sel = 4'b1010;
    reraise = '0;
    n_ack = 0;
    for (int k = 0; k < 60 && n_ack < 10; k++) begin
      i_req_sel = i_req_sel | reraise;
      reraise = '0;
      if (o_req_ack !== 4'b0000) begin
        exp_ack = (n_ack % 2 == 0) ? 4'b0010 : 4'b1000;
        n_cmp++; if (o_req_ack !== exp_ack) begin n_bad++; $display("FAIL b2b_grant #%0d got %b exp %b", n_ack, o_req_ack, exp_ack); end
        n_ack++;
        reraise   = o_req_ack;
        i_req_sel = i_req_sel & ~o_req_ack;
      end
      tick();
    end
    i_req_sel = '0;
    n_cmp++; if (n_ack != 10) begin n_bad++; $display("FAIL b2b_count got %0d exp 10", n_ack); end
  endtask

  task automatic test_timeout();
    logic [NR-1:0] exp_ack;
    do_reset();
    i_req_rd_wr_n[2] = 1'b1;
    i_req_byte_addr[2*AB +: AB] = 16'h0010;
    i_req_sel[2] = 1'b1;
    for (int k = 0; k < 19; k++) begin
      exp_ack = (k == 18) ? 4'b0100 : 4'b0000;
      n_cmp++; if (o_cmd_sel !== (k == 1)) begin n_bad++; $display("FAIL to_sel c%0d got %b exp %b", k, o_cmd_sel, (k == 1)); end
      n_cmp++; if (o_req_ack !== exp_ack) begin n_bad++; $display("FAIL to_ack c%0d got %b exp %b", k, o_req_ack, exp_ack); end
      n_cmp++; if (o_req_err !== exp_ack) begin n_bad++; $display("FAIL to_err c%0d got %b exp %b", k, o_req_err, exp_ack); end
      if (k == 18) begin
        n_cmp++; if (o_req_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL to_rdata got %h exp deadbeef", o_req_rdata); end
        i_req_sel[2] = 1'b0;
      end
      tick();
    end
    // Follow-up transaction from requester 0 must complete normally.
    sl_en = 1'b1; sl_delay = 1; sl_data = 32'hCAFEF00D;
    i_req_rd_wr_n[0] = 1'b1;
    i_req_sel[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_ack = (k == 3) ? 4'b0001 : 4'b0000;
      n_cmp++; if (o_req_ack !== exp_ack) begin n_bad++; $display("FAIL to_next_ack c%0d got %b exp %b", k, o_req_ack, exp_ack); end
      n_cmp++; if (o_req_err !== 4'b0) begin n_bad++; $display("FAIL to_next_err c%0d got %b exp 0000", k, o_req_err); end
      if (k == 3) begin
        n_cmp++; if (o_req_rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL to_next_rdata got %h exp cafef00d", o_req_rdata); end
        i_req_sel[0] = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_late_ack();
    logic [NR-1:0] exp_ack;
    do_reset();
    sl_en = 1'b1; sl_delay = 16; sl_data = 32'h5A5A5A5A;
    i_req_rd_wr_n[1] = 1'b1;
    i_req_sel[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      exp_ack = (k == 18) ? 4'b0010 : 4'b0000;
      n_cmp++; if (o_req_ack !== exp_ack) begin n_bad++; $display("FAIL late_ack c%0d got %b exp %b", k, o_req_ack, exp_ack); end
      n_cmp++; if (o_req_err !== 4'b0) begin n_bad++; $display("FAIL late_err c%0d got %b exp 0000", k, o_req_err); end
      if (k == 18) begin
        n_cmp++; if (o_req_rdata !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL late_rdata got %h exp 5a5a5a5a", o_req_rdata); end
        i_req_sel[1] = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_spurious();
    do_reset();
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    for (int k = 1; k < 4; k++) begin
      n_cmp++; if (o_req_ack !== 4'b0) begin n_bad++; $display("FAIL spur_ack c%0d got %b exp 0000", k, o_req_ack); end
      n_cmp++; if (o_req_rdata !== 32'h0) begin n_bad++; $display("FAIL spur_rdata c%0d got %h exp 0", k, o_req_rdata); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] exp_ack;
    do_reset();
    sl_en = 1'b1; sl_delay = 8; sl_data = 32'h11112222;
    i_req_rd_wr_n[3] = 1'b1;
    i_req_byte_addr[3*AB +: AB] = 16'h0030;
    i_req_wdata[3*DB +: DB] = 32'h33334444;
    i_req_sel[3] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    // Cycle 4 is in WAIT; reset lands at the next edge and holds for two cycles.
    i_srst = 1'b1;
    i_req_sel = '0;
    tick();
    n_cmp++; if (o_cmd_sel !== 1'b0) begin n_bad++; $display("FAIL mid_sel got %b exp 0", o_cmd_sel); end
    n_cmp++; if (o_req_ack !== 4'b0) begin n_bad++; $display("FAIL mid_ack got %b exp 0000", o_req_ack); end
    n_cmp++; if (o_req_err !== 4'b0) begin n_bad++; $display("FAIL mid_err got %b exp 0000", o_req_err); end
    n_cmp++; if (o_cmd_byte_addr !== 16'h0) begin n_bad++; $display("FAIL mid_addr got %h exp 0", o_cmd_byte_addr); end
    n_cmp++; if (o_cmd_wdata !== 32'h0) begin n_bad++; $display("FAIL mid_wdata got %h exp 0", o_cmd_wdata); end
    n_cmp++; if (o_cmd_rd_wr_n !== 1'b0) begin n_bad++; $display("FAIL mid_rdwr got %b exp 0", o_cmd_rd_wr_n); end
    tick();
    i_srst = 1'b0;
    // Slave's late ack arrives at cycle 9 while the DUT idles.
    for (int k = 6; k < 13; k++) begin
      n_cmp++; if (o_req_ack !== 4'b0) begin n_bad++; $display("FAIL mid_noack c%0d got %b exp 0000", k, o_req_ack); end
      n_cmp++; if (o_cmd_sel !== 1'b0) begin n_bad++; $display("FAIL mid_nosel c%0d got %b exp 0", k, o_cmd_sel); end
      tick();
    end
    sl_delay = 1; sl_data = 32'h00000077;
    i_req_rd_wr_n = 4'b1100;
    i_req_byte_addr[2*AB +: AB] = 16'h0020;
    i_req_sel = 4'b1100;
    for (int k = 0; k < 5; k++) begin
      exp_ack = (k == 3) ? 4'b0100 : 4'b0000;
      n_cmp++; if (o_req_ack !== exp_ack) begin n_bad++; $display("FAIL mid_post_ack c%0d got %b exp %b", k, o_req_ack, exp_ack); end
      if (k == 1) begin
        n_cmp++; if (o_cmd_byte_addr !== 16'h0020) begin n_bad++; $display("FAIL mid_post_addr got %h exp 0020", o_cmd_byte_addr); end
      end
      if (k == 3) begin
        n_cmp++; if (o_req_rdata !== 32'h77) begin n_bad++; $display("FAIL mid_post_rdata got %h exp 00000077", o_req_rdata); end
        i_req_sel = '0;
      end
      tick();
    end
  endtask

  initial begin
    n_cmp           = 0;
    n_bad           = 0;
    i_srst          = 1'b1;
    i_req_sel       = '0;
    i_req_rd_wr_n   = '0;
    i_req_byte_addr = '0;
    i_req_wdata     = '0;
    test_reset();
    test_single_read();
    test_all_four();
    test_back_to_back();
    test_timeout();
    test_late_ack();
    test_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test sequence");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_bus_arbiter.md
Name: cmd_bus_arbiter

Overview:
- Shares one command-bus master port between NUM_REQ requesters (e.g. host bridge, self-test engine, boot sequencer).
- Drives per-FPGA config/status slaves: a slave samples sel for one cycle, then returns a one-cycle ack with read data on the following cycle.
- Serializes transactions using round-robin arbitration, a single-cycle sel pulse per transaction, and a no-ack timeout that returns an error response.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_BITS, 16, byte_addr width
CMD_DATA_BITS, 32, wdata/rdata width
TIMEOUT_CYCLES, 16, max cycles spent in WAIT before error (>=2)

Ports:
i_sysclk  in  1  system clock
i_srst  in  1  synchronous reset, active-high
i_req_sel  in  NUM_REQ  per-requester request; held high until its o_req_ack, then dropped
i_req_rd_wr_n  in  NUM_REQ  1=read, 0=write
i_req_byte_addr  in  NUM_REQ*ADDR_BITS  packed, requester k at [k*ADDR_BITS +: ADDR_BITS]
i_req_wdata  in  NUM_REQ*CMD_DATA_BITS  packed write data
o_req_ack  out  NUM_REQ  one-hot, one-cycle completion pulse
o_req_err  out  NUM_REQ  one-cycle pulse coincident with ack on timeout
o_req_rdata  out  CMD_DATA_BITS  shared; valid only while o_req_ack != 0
o_cmd_sel  out  1  one-cycle sel pulse to slave bus
o_cmd_rd_wr_n  out  1  latched rd_wr_n of the grantee
o_cmd_byte_addr  out  ADDR_BITS  latched address
o_cmd_wdata  out  CMD_DATA_BITS  latched write data
i_cmd_rdata  in  CMD_DATA_BITS  slave read data, valid with i_cmd_ack
i_cmd_ack  in  1  slave completion pulse

Behaviour:
- All outputs registered. Reset values: all outputs 0. Reset also sets state=IDLE, timer=0, and last_grant=NUM_REQ-1, so requester 0 has first priority.
- Reset asserted mid-transaction: next cycle o_cmd_sel=0 and o_req_ack=0. Any later i_cmd_ack is ignored until a new ISSUE.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any i_req_sel is high, select the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Latch the winner's index, rd_wr_n, addr and wdata, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - o_cmd_sel=1 for exactly this cycle; address/data/rd_wr_n are stable from ISSUE through DONE.
  - Clear timer, then go to WAIT.
- WAIT:
  - If i_cmd_ack=1: o_req_rdata<=i_cmd_rdata (reads) or hold previous value (writes); o_req_ack[g]<=1; go to DONE.
  - Else if timer==TIMEOUT_CYCLES-1: o_req_ack[g]<=1, o_req_err[g]<=1, o_req_rdata<=CMD_ERR_RDATA (32'hDEADBEEF); go to DONE.
  - Otherwise timer++.
  - An ack arriving in the final WAIT cycle wins over the timeout, so err=0.
- DONE:
  - The ack/err pulse is visible this cycle.
  - last_grant<=g; go to IDLE.
  - The grantee's sel is ignored this cycle (it is dropping it).
- i_cmd_ack in IDLE, ISSUE or DONE is spurious and ignored (no ack forwarded).
- Latency, with a request seen in IDLE at cycle 0: o_cmd_sel at 1; slave ack at 2; o_req_ack at 3; next IDLE at 4. Minimum 4 cycles per transaction.
- A requester that drops sel before being granted is simply not selected. Changing addr/data while sel is high before grant is allowed; values are latched at grant.
- Timer width is $clog2(TIMEOUT_CYCLES); the counter never wraps.

Decomposition:
- Package cmd_arb_pkg:
  - state enum (IDLE/ISSUE/WAIT/DONE)
  - CMD_ERR_RDATA = 32'hDEADBEEF
  - function rr_pick(req, last) returning index and valid
- One sub-module, rr_arbiter: combinational rotating-priority picker, parameterised by NUM_REQ, with inputs req vector and last_grant and outputs grant index and valid.

Test Plan:
- Req0 read addr 0x0004, slave model acks 1 cycle after sel with 0x12345678 -> o_cmd_sel high only at cycle 1, o_cmd_byte_addr=0x0004; o_req_ack=4'b0001 at cycle 3 with o_req_rdata=0x12345678, o_req_err=0.
- All 4 requesters assert together (writes 0xA0..0xA3 to addr 4) -> slave sees wdata 0xA0, 0xA1, 0xA2, 0xA3 in that order, sel pulses 4 cycles apart, acks 0001, 0010, 0100, 1000.
- Req1 and req3 re-request immediately after each ack for 10 transactions -> grants alternate 1, 3, 1, 3…; no requester is granted twice in a row while the other is pending.
- Slave never acks, TIMEOUT_CYCLES=16, req2 read -> sel at cycle 1; o_req_ack[2]=1 and o_req_err[2]=1 at cycle 18; o_req_rdata=0xDEADBEEF; next request is served normally.
- Slave acks at cycle 17 (last WAIT cycle) with 0x5A5A5A5A -> ack at 18 with err=0, rdata 0x5A5A5A5A. Separately, spurious i_cmd_ack in IDLE -> no o_req_ack.
- i_srst asserted during WAIT, late slave ack arrives after reset release -> all outputs 0 during reset, no o_req_ack afterwards, and the first post-reset grant goes to the lowest pending index.
